conv_spike_pooling: RTL and testbench

CONV_SPIKE_POOLING -- requirements
Module: conv_spike_pooling

---
 rtl/conv_pkg.sv | 32 +++
 rtl/conv_threshold_unit.sv | 42 ++++
 rtl/conv_spike_pooling.sv | 157 +++++++++++++++
 tb/tb_conv_spike_pooling.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and defaults for the spike-pooling scan.
// The optional membrane leak is enabled by defining POOL_LEAK_EN.
package conv_pkg;

    localparam int CONV_IMG_WIDTH       = 8;
    localparam int CONV_IMG_HEIGHT      = 8;
    localparam int CONV_OUT_CHANNELS    = 2;
    localparam int CONV_BITS_PER_NEURON = 9;
    localparam int CONV_LEAK_SHIFT      = 3;

    // Coordinates are sized to cover the larger axis so one width serves both.
    localparam int WIN_MAX_DIM = (CONV_IMG_WIDTH >= CONV_IMG_HEIGHT) ? CONV_IMG_WIDTH / 2 : CONV_IMG_HEIGHT / 2;
    localparam int WIN_COORD_W = (WIN_MAX_DIM > 1) ? $clog2(WIN_MAX_DIM) : 1;

    typedef logic [CONV_OUT_CHANNELS*CONV_BITS_PER_NEURON-1:0] feature_map_t;

    typedef struct packed {
        logic                         timestep;
        logic [WIN_COORD_W-1:0]       wx;
        logic [WIN_COORD_W-1:0]       wy;
        logic [CONV_OUT_CHANNELS-1:0] spikes;
    } output_vector_t;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        DRAIN,
        EMIT,
        DONE
    } pool_state_t;

endpackage

// File: rtl/conv_threshold_unit.sv
// Per-word fire detection and membrane write-back value (fire -> 0, otherwise kept or leaked).
// Leak applied only when POOL_LEAK_EN is defined.
module conv_threshold_unit
    import conv_pkg::*;
#(
    parameter int OUT_CHANNELS    = CONV_OUT_CHANNELS,
    parameter int BITS_PER_NEURON = CONV_BITS_PER_NEURON,
    parameter int LEAK_SHIFT      = CONV_LEAK_SHIFT
)(
    input  logic signed [BITS_PER_NEURON-1:0] i_threshold,
    input  feature_map_t                      i_word,
    output feature_map_t                      o_word,
    output logic [OUT_CHANNELS-1:0]           o_fire
);

`ifdef POOL_LEAK_EN
    localparam bit LEAK_ON = 1'b1;
`else
    localparam bit LEAK_ON = 1'b0;
`endif

    logic signed [BITS_PER_NEURON-1:0] w_val;
    logic signed [BITS_PER_NEURON-1:0] w_leaked;

    always_comb begin
        o_word   = '0;
        o_fire   = '0;
        w_val    = '0;
        w_leaked = '0;
        for (int c = 0; c < OUT_CHANNELS; c++) begin
            w_val    = $signed(i_word[c*BITS_PER_NEURON +: BITS_PER_NEURON]);
            w_leaked = w_val - (w_val >>> LEAK_SHIFT);
            if (w_val >= i_threshold) begin
                o_fire[c]                                         = 1'b1;
                o_word[c*BITS_PER_NEURON +: BITS_PER_NEURON]      = '0;
            end else begin
                o_word[c*BITS_PER_NEURON +: BITS_PER_NEURON]      = LEAK_ON ? w_leaked : w_val;
            end
        end
    end

endmodule

// File: rtl/conv_spike_pooling.sv
// 2x2 spike pooling scan: reads each window, resets fired neurons in place and emits pooled spikes.
// Optional leak on non-fired neurons via POOL_LEAK_EN (see conv_threshold_unit).
module conv_spike_pooling
    import conv_pkg::*;
#(
    parameter int IMG_WIDTH       = CONV_IMG_WIDTH,
    parameter int IMG_HEIGHT      = CONV_IMG_HEIGHT,
    parameter int OUT_CHANNELS    = CONV_OUT_CHANNELS,
    parameter int BITS_PER_NEURON = CONV_BITS_PER_NEURON,
    parameter int LEAK_SHIFT      = CONV_LEAK_SHIFT
)(
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           start,
    input  logic                                           timestep,
    input  logic signed [BITS_PER_NEURON-1:0]              threshold,
    output logic                                           busy,
    output logic                                           done,
    output logic                                           fm_rd_en,
    output logic [$clog2(IMG_WIDTH*IMG_HEIGHT)-1:0]        fm_rd_addr,
    input  feature_map_t                                   fm_rd_data,
    output logic                                           fm_wr_en,
    output logic [$clog2(IMG_WIDTH*IMG_HEIGHT)-1:0]        fm_wr_addr,
    output feature_map_t                                   fm_wr_data,
    output logic                                           out_valid,
    input  logic                                           out_ready,
    output output_vector_t                                 out_event
);

    localparam int AW = $clog2(IMG_WIDTH*IMG_HEIGHT);
    localparam logic [WIN_COORD_W-1:0] WX_LAST = WIN_COORD_W'(IMG_WIDTH/2 - 1);
    localparam logic [WIN_COORD_W-1:0] WY_LAST = WIN_COORD_W'(IMG_HEIGHT/2 - 1);

    pool_state_t                       r_state;
    pool_state_t                       w_next;
    logic [WIN_COORD_W-1:0]            r_wx;
    logic [WIN_COORD_W-1:0]            r_wy;
    logic [1:0]                        r_k;
    logic                              r_ts;
    logic signed [BITS_PER_NEURON-1:0] r_thr;
    logic [OUT_CHANNELS-1:0]           r_spikes;
    logic [OUT_CHANNELS-1:0]           w_fire;
    logic [OUT_CHANNELS-1:0]           w_win_spikes;
    logic                              r_wr_en;
    logic [AW-1:0]                     r_wr_addr;
    logic [AW-1:0]                     w_rd_addr;
    logic [WIN_COORD_W:0]              w_row;
    logic [WIN_COORD_W:0]              w_col;
    feature_map_t                      w_new_word;
    output_vector_t                    r_event;
    logic                              w_last;
    logic                              w_advance;

    conv_threshold_unit #(
        .OUT_CHANNELS    (OUT_CHANNELS),
        .BITS_PER_NEURON (BITS_PER_NEURON),
        .LEAK_SHIFT      (LEAK_SHIFT)
    ) u_threshold (
        .i_threshold (r_thr),
        .i_word      (fm_rd_data),
        .o_word      (w_new_word),
        .o_fire      (w_fire)
    );

    // r_k[0] selects the column and r_k[1] the row inside the current 2x2 window.
    always_comb begin
        w_row     = {r_wy, r_k[1]};
        w_col     = {r_wx, r_k[0]};
        w_rd_addr = AW'(w_row) * AW'(IMG_WIDTH) + AW'(w_col);
    end

    assign w_win_spikes = r_spikes | w_fire;
    assign w_last       = (r_wx == WX_LAST) && (r_wy == WY_LAST);
    assign w_advance    = ((r_state == DRAIN) && (w_win_spikes == '0)) ||
                          ((r_state == EMIT) && out_ready);

    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE);
    assign out_valid  = (r_state == EMIT);
    assign out_event  = r_event;
    assign fm_rd_en   = (r_state == READ);
    assign fm_rd_addr = fm_rd_en ? w_rd_addr : '0;
    assign fm_wr_en   = r_wr_en;
    assign fm_wr_addr = r_wr_addr;
    assign fm_wr_data = r_wr_en ? w_new_word : '0;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = READ;
            READ:    if (r_k == 2'd3) w_next = DRAIN;
            DRAIN: begin
                if (w_win_spikes != '0) w_next = EMIT;
                else if (w_last)        w_next = DONE;
                else                    w_next = READ;
            end
            EMIT:    if (out_ready) w_next = w_last ? DONE : READ;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Read data returns one cycle later, so the write-back strobe and address are the read request delayed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_wx      <= '0;
            r_wy      <= '0;
            r_k       <= '0;
            r_ts      <= 1'b0;
            r_thr     <= '0;
            r_spikes  <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_event   <= '0;
        end else begin
            r_state   <= w_next;
            r_wr_en   <= fm_rd_en;
            r_wr_addr <= fm_rd_addr;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_ts     <= timestep;
                        r_thr    <= threshold;
                        r_wx     <= '0;
                        r_wy     <= '0;
                        r_k      <= '0;
                        r_spikes <= '0;
                    end
                end
                READ: begin
                    r_k <= r_k + 2'd1;
                    if (r_wr_en) r_spikes <= w_win_spikes;
                end
                DRAIN: begin
                    r_spikes <= '0;
                    if (w_win_spikes != '0) begin
                        r_event.timestep <= r_ts;
                        r_event.wx       <= r_wx;
                        r_event.wy       <= r_wy;
                        r_event.spikes   <= w_win_spikes;
                    end
                end
                default: ;
            endcase
            if (w_advance) begin
                if (r_wx == WX_LAST) begin
                    r_wx <= '0;
                    r_wy <= r_wy + 1'b1;
                end else begin
                    r_wx <= r_wx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_spike_pooling.sv
// Scoreboard bench for conv_spike_pooling: a window-level model predicts reads, write-backs and events.
// Build with POOL_LEAK_EN defined to exercise the leak variant.
module tb_conv_spike_pooling;
    import conv_pkg::*;

    localparam int B     = CONV_BITS_PER_NEURON;
    localparam int NCH   = CONV_OUT_CHANNELS;
    localparam int W     = CONV_IMG_WIDTH;
    localparam int H     = CONV_IMG_HEIGHT;
    localparam int DEPTH = W * H;

    logic                  clk;
    logic                  rst_n;
    logic                  start;
    logic                  timestep;
    logic signed [B-1:0]   threshold;
    logic                  busy;
    logic                  done;
    logic                  fm_rd_en;
    logic [5:0]            fm_rd_addr;
    feature_map_t          fm_rd_data;
    logic                  fm_wr_en;
    logic [5:0]            fm_wr_addr;
    feature_map_t          fm_wr_data;
    logic                  out_valid;
    logic                  out_ready;
    output_vector_t        out_event;

    feature_map_t          mem     [DEPTH];
    feature_map_t          initMem [DEPTH];
    feature_map_t          expMem  [DEPTH];
    logic                  loadReq;
    int                    expReads[$];
    output_vector_t        expEvents[$];
    int                    nExp;
    int                    nChecks;
    int                    nPass;
    bit                    monOn;
    int                    readyMode;
    int                    stallLeft;
    bit                    prevRdEn;
    logic [5:0]            prevRdAddr;
    bit                    holdPending;
    output_vector_t        holdEvt;
    output_vector_t        lastEvt;
    int                    gotEvents;

    conv_spike_pooling dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .timestep   (timestep),
        .threshold  (threshold),
        .busy       (busy),
        .done       (done),
        .fm_rd_en   (fm_rd_en),
        .fm_rd_addr (fm_rd_addr),
        .fm_rd_data (fm_rd_data),
        .fm_wr_en   (fm_wr_en),
        .fm_wr_addr (fm_wr_addr),
        .fm_wr_data (fm_wr_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_event  (out_event)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Feature-map memory with one-cycle read latency; loadReq copies a prepared image in.
    always @(posedge clk) begin
        if (loadReq) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= initMem[i];
        end else begin
            if (fm_rd_en) fm_rd_data <= mem[fm_rd_addr];
            if (fm_wr_en) mem[fm_wr_addr] <= fm_wr_data;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nChecks++;
        if (actual === expected) nPass++;
        else $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    endtask

    // Reference: walk windows row-major, visit the four pixels, apply fire/reset/leak per channel.
    task automatic buildModel(input logic ts, input logic signed [B-1:0] thr);
        logic signed [B-1:0] v;
        logic signed [B-1:0] nv;
        logic [NCH-1:0]      sp;
        output_vector_t      ev;
        int                  a;
        expReads.delete();
        expEvents.delete();
        nExp = 0;
        for (int i = 0; i < DEPTH; i++) expMem[i] = mem[i];
        for (int wy = 0; wy < H/2; wy++) begin
            for (int wx = 0; wx < W/2; wx++) begin
                sp = '0;
                for (int p = 0; p < 4; p++) begin
                    a = (2*wy + p/2) * W + 2*wx + p%2;
                    expReads.push_back(a);
                    for (int c = 0; c < NCH; c++) begin
                        v = expMem[a][c*B +: B];
                        if (v >= thr) begin
                            sp[c] = 1'b1;
                            nv    = '0;
                        end else begin
`ifdef POOL_LEAK_EN
                            nv = v - (v >>> 3);
`else
                            nv = v;
`endif
                        end
                        expMem[a][c*B +: B] = nv;
                    end
                end
                if (sp != '0) begin
                    ev.timestep = ts;
                    ev.wx       = WIN_COORD_W'(wx);
                    ev.wy       = WIN_COORD_W'(wy);
                    ev.spikes   = sp;
                    expEvents.push_back(ev);
                    nExp++;
                end
            end
        end
    endtask

    // Monitor: drives out_ready, then checks reads, write-backs and handshaked events against the scoreboard.
    always @(negedge clk) begin
        if (!monOn) begin
            out_ready   = 1'b1;
            prevRdEn    = 1'b0;
            prevRdAddr  = '0;
            holdPending = 1'b0;
        end else begin
            if (readyMode == 1) out_ready = 1'($urandom_range(0, 1));
            else if (stallLeft > 0) begin
                out_ready = 1'b0;
                if (out_valid) stallLeft--;
            end else out_ready = 1'b1;

            if (holdPending) begin
                checkOutput("holdValid", out_valid, 1);
                checkOutput("holdEvent", out_event, holdEvt);
            end
            if (out_valid) checkOutput("noReadWhileEmit", fm_rd_en, 0);

            checkOutput("wrEnTiming", fm_wr_en, prevRdEn);
            if (prevRdEn) checkOutput("wrAddr", fm_wr_addr, prevRdAddr);
            if (fm_wr_en) checkOutput("wrData", fm_wr_data, expMem[fm_wr_addr]);

            if (fm_rd_en) begin
                if (expReads.size() == 0) checkOutput("extraRead", 1, 0);
                else checkOutput("rdAddr", fm_rd_addr, expReads.pop_front());
            end
            prevRdEn   = fm_rd_en;
            prevRdAddr = fm_rd_addr;

            if (out_valid && out_ready) begin
                if (expEvents.size() == 0) checkOutput("extraEvent", 1, 0);
                else checkOutput("event", out_event, expEvents.pop_front());
                lastEvt = out_event;
                gotEvents++;
                holdPending = 1'b0;
            end else if (out_valid) begin
                holdPending = 1'b1;
                holdEvt     = out_event;
            end else holdPending = 1'b0;
        end
    end

    task automatic loadMem();
        @(negedge clk) loadReq = 1'b1;
        @(negedge clk) loadReq = 1'b0;
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"},    busy,       0);
        checkOutput({tag, "_done"},    done,       0);
        checkOutput({tag, "_valid"},   out_valid,  0);
        checkOutput({tag, "_rdEn"},    fm_rd_en,   0);
        checkOutput({tag, "_wrEn"},    fm_wr_en,   0);
        checkOutput({tag, "_rdAddr"},  fm_rd_addr, 0);
        checkOutput({tag, "_wrAddr"},  fm_wr_addr, 0);
        checkOutput({tag, "_wrData"},  fm_wr_data, 0);
        checkOutput({tag, "_event"},   out_event,  0);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        #1;
        checkResetOutputs("midReset");
        monOn = 1'b0;
        expReads.delete();
        expEvents.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checkOutput("postResetNoWrite", fm_wr_en, 0);
            checkOutput("postResetIdle", busy, 0);
        end
    endtask

    // mode: 0 always ready, 1 random ready, 2 ten-cycle stall on first event.
    task automatic applyStimulus(input logic ts, input logic signed [B-1:0] thr, input int mode,
                                 input int abortAt, input int pulseAt);
        int cyc;
        bit seenDone;
        int mism;
        buildModel(ts, thr);
        readyMode = mode;
        stallLeft = (mode == 2) ? 10 : 0;
        gotEvents = 0;
        @(negedge clk);
        monOn     = 1'b1;
        timestep  = ts;
        threshold = thr;
        start     = 1'b1;
        cyc       = 0;
        seenDone  = 1'b0;
        while (cyc < 3000 && !seenDone) begin
            @(posedge clk);
            cyc++;
            #1;
            if (cyc == 1) start = 1'b0;
            if (pulseAt > 1 && cyc == pulseAt) begin
                start     = 1'b1;
                timestep  = ~ts;
                threshold = B'($urandom);
            end else if (pulseAt > 1 && cyc == pulseAt + 1) start = 1'b0;
            if (cyc == abortAt) begin
                doReset();
                return;
            end
            @(negedge clk);
            if (cyc == 1) checkOutput("busyAfterStart", busy, 1);
            if (done) seenDone = 1'b1;
        end
        checkOutput("doneSeen", seenDone, 1);
        if (mode == 0) checkOutput("doneCycle", cyc, 81 + nExp);
        checkOutput("eventsLeft", expEvents.size(), 0);
        checkOutput("readsLeft", expReads.size(), 0);
        @(negedge clk);
        checkOutput("donePulse", done, 0);
        checkOutput("idleBusy", busy, 0);
        mism = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== expMem[i]) mism++;
        checkOutput("memImage", mism, 0);
    endtask

    initial begin
        output_vector_t ev;
        logic [B-1:0]   lv;
        nChecks   = 0;
        nPass     = 0;
        monOn     = 1'b0;
        readyMode = 0;
        stallLeft = 0;
        gotEvents = 0;
        loadReq   = 1'b0;
        rst_n     = 1'b0;
        start     = 1'b0;
        timestep  = 1'b0;
        threshold = '0;
        repeat (2) @(negedge clk);
        checkResetOutputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] all-zero scan");
        for (int i = 0; i < DEPTH; i++) initMem[i] = '0;
        loadMem();
        applyStimulus(1'b0, 9'sd100, 0, 0, 0);
        checkOutput("zeroEvents", gotEvents, 0);

        $display("[TB] single fire at address 9");
        initMem[9] = {9'd0, 9'd120};
        loadMem();
        applyStimulus(1'b1, 9'sd100, 0, 0, 0);
        checkOutput("a9Events", gotEvents, 1);
        ev = '{timestep: 1'b1, wx: '0, wy: '0, spikes: 2'b01};
        checkOutput("a9Event", lastEvt, ev);
        checkOutput("a9Cleared", mem[9], 0);

        $display("[TB] equal-to-threshold fire at address 63");
        for (int i = 0; i < DEPTH; i++) initMem[i] = '0;
        initMem[63] = {9'd100, 9'd0};
        loadMem();
        applyStimulus(1'b0, 9'sd100, 0, 0, 0);
        ev = '{timestep: 1'b0, wx: 2'd3, wy: 2'd3, spikes: 2'b10};
        checkOutput("a63Event", lastEvt, ev);
        checkOutput("a63Events", gotEvents, 1);

        $display("[TB] back-pressure on first of two events");
        initMem[63] = {9'd150, 9'd0};
        initMem[0]  = {9'd0, 9'd120};
        loadMem();
        applyStimulus(1'b1, 9'sd100, 2, 0, 0);
        checkOutput("stallEvents", gotEvents, 2);

        $display("[TB] leak check");
        for (int i = 0; i < DEPTH; i++) initMem[i] = '0;
        initMem[5] = {9'd0, 9'd64};
        initMem[6] = {9'h1F0, 9'd0};
        loadMem();
        applyStimulus(1'b0, 9'sd100, 0, 0, 0);
`ifdef POOL_LEAK_EN
        lv = 9'd56;
`else
        lv = 9'd64;
`endif
        checkOutput("leakPos", mem[5][8:0], lv);
`ifdef POOL_LEAK_EN
        lv = 9'h1F2;
`else
        lv = 9'h1F0;
`endif
        checkOutput("leakNeg", mem[6][17:9], lv);

        $display("[TB] reset mid-scan then fresh scan");
        for (int i = 0; i < DEPTH; i++) initMem[i] = feature_map_t'($urandom);
        initMem[0] = {9'd0, 9'd150};
        loadMem();
        applyStimulus(1'b1, 9'sd100, 0, 20, 0);
        applyStimulus(1'b0, 9'sd120, 0, 0, 0);

        $display("[TB] random scans");
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < DEPTH; i++) initMem[i] = feature_map_t'($urandom);
            loadMem();
            applyStimulus(1'($urandom_range(0, 1)), 9'($urandom_range(60, 220)),
                          (s % 2 == 0) ? 0 : 1, 0, 30);
        end

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
